// File: rtl/medf_frame_ctrl.sv
// medf_frame_ctrl
// Frame-level controller that walks a 3x3 median filter across an image.
// For each output pixel it accepts one window from the window generator,
// launches the filter, waits for its done pulse (watchdog-bounded), and
// emits one output strobe. Row/column counters track the raster position.
//
// Optional build macro: MEDF_BORDER_BYPASS_EN
//   When defined, border pixels (first/last row, first/last column) bypass
//   the filter. The window centre pixel is copied straight to the output.
//   When undefined, every pixel goes through the filter and no border
//   decode exists.
module medf_frame_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       start,
    input  logic       win_vld,
    output logic       win_rdy,
    input  logic [7:0] center_pix,
    output logic       medf_start,
    input  logic       medf_done,
    input  logic [7:0] medf_data,
    output logic       pix_out_vld,
    output logic [7:0] pix_out,
    output logic       busy,
    output logic       frame_done,
    output logic       err_tmo
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    // The watchdog fires in the RUN cycle where the count equals TIMEOUT-1,
    // i.e. on the TIMEOUT-th consecutive RUN cycle without a done pulse.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        RUN    = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_nxt;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_nxt;
    logic [WD_W-1:0]  r_wdog;
    logic [WD_W-1:0]  w_wdog_nxt;
    logic [7:0]       r_pix;
    logic [7:0]       w_pix_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_pix;
    logic             w_wdog_exp;

    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);
    assign w_last_pix = w_last_col && w_last_row;
    assign w_wdog_exp = (r_wdog == WD_LAST);

`ifdef MEDF_BORDER_BYPASS_EN
    logic w_border;
    assign w_border = (r_row == '0) || w_last_row || (r_col == '0) || w_last_col;
`else
    // The centre pixel is only needed by the bypass path.
    logic w_unused_center;
    assign w_unused_center = &{1'b0, center_pix};
`endif

    // State and datapath registers; reset returns the block to a quiet idle.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_wdog  <= '0;
            r_pix   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_wdog  <= w_wdog_nxt;
            r_pix   <= w_pix_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state, counter updates and per-state outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_wdog_nxt  = '0;
        w_pix_nxt   = r_pix;
        w_err_nxt   = r_err;
        win_rdy     = 1'b0;
        medf_start  = 1'b0;
        pix_out_vld = 1'b0;
        frame_done  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACCEPT;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end

            ACCEPT: begin
                win_rdy = 1'b1;
                if (win_vld) begin
`ifdef MEDF_BORDER_BYPASS_EN
                    if (w_border) begin
                        w_pix_nxt   = center_pix;
                        w_state_nxt = OUT;
                    end else begin
                        medf_start  = 1'b1;
                        w_state_nxt = RUN;
                    end
`else
                    medf_start  = 1'b1;
                    w_state_nxt = RUN;
`endif
                end
            end

            RUN: begin
                // A done pulse on the watchdog's final cycle still wins.
                if (medf_done) begin
                    w_pix_nxt   = medf_data;
                    w_state_nxt = OUT;
                end else if (w_wdog_exp) begin
                    w_err_nxt   = 1'b1;
                    w_pix_nxt   = 8'h00;
                    w_state_nxt = OUT;
                end else begin
                    w_wdog_nxt  = r_wdog + WD_W'(1);
                end
            end

            OUT: begin
                pix_out_vld = 1'b1;
                if (w_last_pix) begin
                    frame_done  = 1'b1;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (w_last_col) begin
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_state_nxt = ACCEPT;
                end else begin
                    w_col_nxt   = r_col + COL_W'(1);
                    w_state_nxt = ACCEPT;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign busy    = (r_state != IDLE);
    assign pix_out = r_pix;
    assign err_tmo = r_err;

endmodule

// File: tb/tb_medf_frame_ctrl.sv
// Testbench for medf_frame_ctrl (IMG_W=4, IMG_H=3, TIMEOUT=15).
// A full-frame vector table with fixed filter latencies is followed by short
// hand sequences for reset and ignored inputs, and then a randomized phase.
// The reference model keeps a timeline of expected events per pixel
// (handshake cycle, output cycle, output value) derived from the latency
// rules rather than from the controller's state machine.
module tb_medf_frame_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int T    = 15;
    localparam int NPIX = W * H;
`ifdef MEDF_BORDER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       start;
    logic       win_vld;
    logic       win_rdy;
    logic [7:0] center_pix;
    logic       medf_start;
    logic       medf_done;
    logic [7:0] medf_data;
    logic       pix_out_vld;
    logic [7:0] pix_out;
    logic       busy;
    logic       frame_done;
    logic       err_tmo;

    always #5 CLK = ~CLK;

    medf_frame_ctrl #(.IMG_W(W), .IMG_H(H), .TIMEOUT(T)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start      (start),
        .win_vld    (win_vld),
        .win_rdy    (win_rdy),
        .center_pix (center_pix),
        .medf_start (medf_start),
        .medf_done  (medf_done),
        .medf_data  (medf_data),
        .pix_out_vld(pix_out_vld),
        .pix_out    (pix_out),
        .busy       (busy),
        .frame_done (frame_done),
        .err_tmo    (err_tmo)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // stimulus policy
    bit         p_rst_n         = 1'b0;
    bit         p_start_once    = 1'b0;
    int         p_vld_pct       = 0;
    int         p_spur_start    = 0;
    int         p_spur_done     = 0;
    bit         p_fix           = 1'b1;
    int         p_fix_dly       = 4;
    logic [7:0] p_fix_data      = 8'h5A;
    logic [7:0] p_center        = 8'h00;
    bit         p_rand_center   = 1'b0;

    // reference model: event timeline
    bit         m_busy;
    int         m_idx;
    int         m_out_cyc  = -1;
    int         m_done_cyc = -1;
    int         m_hs_cyc   = -1;
    logic [7:0] m_done_data;
    logic [7:0] m_pend_pix;
    bit         m_pend_tmo;
    logic [7:0] m_pix;
    bit         m_err;

    // observations from the DUT
    int         o_hs, o_vld, o_nstart, o_nvld;
    logic [7:0] o_pix;
    bit         o_err, o_fd, o_got_vld;

    typedef struct {
        int         dly;     // filter done delay after launch, 0 = never
        logic [7:0] data;
        logic [7:0] ctr;
        int         lat;     // handshake -> strobe, filtered build
        logic [7:0] pix;
        int         lat_b;   // handshake -> strobe, bypass build
        logic [7:0] pix_b;
        bit         err;
        bit         fd;
    } row_t;
    row_t tbl [NPIX];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit is_border(input int idx);
        int r, c;
        r = idx / W;
        c = idx % W;
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    task automatic model_reset();
        m_busy     = 1'b0;
        m_idx      = 0;
        m_out_cyc  = -1;
        m_done_cyc = -1;
        m_hs_cyc   = -1;
        m_pend_tmo = 1'b0;
        m_pix      = 8'h00;
        m_err      = 1'b0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later.
    task automatic tick();
        bit         in_run, exp_rdy, exp_start, exp_vld, exp_fd, byp_px;
        int         d;
        logic [7:0] dat;
        @(negedge CLK);
        cyc++;
        RSTn         = p_rst_n;
        start        = p_start_once || ($urandom_range(99) < p_spur_start);
        p_start_once = 1'b0;
        win_vld      = ($urandom_range(99) < p_vld_pct);
        center_pix   = p_rand_center ? 8'($urandom) : p_center;
        in_run       = (m_out_cyc >= 0) && (cyc > m_hs_cyc) && (cyc < m_out_cyc);
        if (cyc == m_done_cyc) begin
            medf_done = 1'b1;
            medf_data = m_done_data;
        end else begin
            medf_done = !in_run && ($urandom_range(99) < p_spur_done);
            medf_data = 8'($urandom);
        end
        #1;
        if (!RSTn) begin
            model_reset();
            chk("rst_busy", busy, 0);
            chk("rst_win_rdy", win_rdy, 0);
            chk("rst_medf_start", medf_start, 0);
            chk("rst_pix_out_vld", pix_out_vld, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_pix_out", pix_out, 0);
            chk("rst_err_tmo", err_tmo, 0);
            return;
        end
        if (cyc == m_out_cyc) begin
            m_pix = m_pend_pix;
            if (m_pend_tmo) m_err = 1'b1;
        end
        byp_px    = BYP && is_border(m_idx);
        exp_vld   = (cyc == m_out_cyc);
        exp_rdy   = m_busy && (m_out_cyc < 0);
        exp_start = exp_rdy && win_vld && !byp_px;
        exp_fd    = exp_vld && (m_idx == NPIX - 1);
        chk("busy", busy, m_busy);
        chk("win_rdy", win_rdy, exp_rdy);
        chk("medf_start", medf_start, exp_start);
        chk("pix_out_vld", pix_out_vld, exp_vld);
        chk("frame_done", frame_done, exp_fd);
        chk("pix_out", pix_out, m_pix);
        chk("err_tmo", err_tmo, m_err);

        if (win_rdy && win_vld) o_hs = cyc;
        if (medf_start) o_nstart++;
        if (pix_out_vld) begin
            o_got_vld = 1'b1;
            o_vld     = cyc;
            o_pix     = pix_out;
            o_err     = err_tmo;
            o_fd      = frame_done;
            o_nvld++;
        end

        if (exp_rdy && win_vld) begin
            m_hs_cyc   = cyc;
            m_pend_tmo = 1'b0;
            if (byp_px) begin
                m_out_cyc  = cyc + 1;
                m_pend_pix = center_pix;
                m_done_cyc = -1;
            end else begin
                d   = p_fix ? p_fix_dly : (($urandom_range(11) == 0) ? 0 : int'($urandom_range(T, 1)));
                dat = p_fix ? p_fix_data : 8'($urandom);
                if (d >= 1 && d <= T) begin
                    m_done_cyc  = cyc + d;
                    m_done_data = dat;
                    m_out_cyc   = cyc + d + 1;
                    m_pend_pix  = dat;
                end else begin
                    m_done_cyc = -1;
                    m_out_cyc  = cyc + T + 1;
                    m_pend_pix = 8'h00;
                    m_pend_tmo = 1'b1;
                end
            end
        end else if (exp_vld) begin
            m_out_cyc = -1;
            m_idx++;
            if (m_idx == NPIX) begin
                m_idx  = 0;
                m_busy = 1'b0;
            end
        end else if (!m_busy && start) begin
            m_busy = 1'b1;
            m_err  = 1'b0;
        end
    endtask

    initial begin
        //             dly data   ctr    lat pix    lat_b pix_b err fd
        tbl[0]  = '{4,  8'h5A, 8'hC3, 5,  8'h5A, 1,  8'hC3, 0, 0};
        tbl[1]  = '{1,  8'h11, 8'h22, 2,  8'h11, 1,  8'h22, 0, 0};
        tbl[2]  = '{15, 8'h33, 8'h44, 16, 8'h33, 1,  8'h44, 0, 0};
        tbl[3]  = '{4,  8'h5A, 8'h66, 5,  8'h5A, 1,  8'h66, 0, 0};
        tbl[4]  = '{2,  8'h77, 8'h88, 3,  8'h77, 1,  8'h88, 0, 0};
        tbl[5]  = '{4,  8'h5A, 8'h99, 5,  8'h5A, 5,  8'h5A, 0, 0};
        tbl[6]  = '{0,  8'hAB, 8'hCD, 16, 8'h00, 16, 8'h00, 1, 0};
        tbl[7]  = '{4,  8'h12, 8'h34, 5,  8'h12, 1,  8'h34, 1, 0};
        tbl[8]  = '{3,  8'h56, 8'h78, 4,  8'h56, 1,  8'h78, 1, 0};
        tbl[9]  = '{4,  8'h9A, 8'hBC, 5,  8'h9A, 1,  8'hBC, 1, 0};
        tbl[10] = '{5,  8'hDE, 8'hF0, 6,  8'hDE, 1,  8'hF0, 1, 0};
        tbl[11] = '{4,  8'h5A, 8'h0F, 5,  8'h5A, 1,  8'h0F, 1, 1};

        RSTn       = 1'b0;
        start      = 1'b0;
        win_vld    = 1'b0;
        center_pix = 8'h00;
        medf_done  = 1'b0;
        medf_data  = 8'h00;
        model_reset();

        // reset, then idle without start
        repeat (2) tick();
        p_rst_n = 1'b1;
        repeat (3) tick();

        // full frame from the vector table, win_vld held high
        p_vld_pct     = 100;
        p_fix         = 1'b1;
        p_rand_center = 1'b0;
        p_start_once  = 1'b1;
        tick();
        o_nstart = 0;
        o_nvld   = 0;
        for (int i = 0; i < NPIX; i++) begin
            p_fix_dly  = tbl[i].dly;
            p_fix_data = tbl[i].data;
            p_center   = tbl[i].ctr;
            o_got_vld  = 1'b0;
            for (int k = 0; k < 40 && !o_got_vld; k++) tick();
            if (!o_got_vld) begin
                chk($sformatf("tbl%0d_strobe_timeout", i), 0, 1);
            end else begin
                chk($sformatf("tbl%0d_latency", i), o_vld - o_hs, BYP ? tbl[i].lat_b : tbl[i].lat);
                chk($sformatf("tbl%0d_pix", i), o_pix, BYP ? tbl[i].pix_b : tbl[i].pix);
                chk($sformatf("tbl%0d_err", i), o_err, tbl[i].err);
                chk($sformatf("tbl%0d_frame_done", i), o_fd, tbl[i].fd);
            end
        end
        tick();
        chk("busy_after_frame", busy, 0);
        chk("strobes_per_frame", o_nvld, NPIX);
        chk("launches_per_frame", o_nstart, BYP ? 2 : NPIX);

        // err_tmo stays through the start cycle and clears after it
        p_vld_pct    = 0;
        p_start_once = 1'b1;
        tick();
        chk("err_in_start_cycle", err_tmo, 1);
        tick();
        chk("err_cleared_by_start", err_tmo, 0);

        // start while busy and medf_done in ACCEPT are ignored
        o_nvld       = 0;
        p_spur_start = 100;
        p_spur_done  = 100;
        repeat (5) tick();
        p_spur_start = 0;
        p_spur_done  = 0;
        chk("spurious_no_strobe", o_nvld, 0);
        chk("spurious_still_accept", win_rdy, 1);

        // reset in the middle of RUN, then windows without a start
        p_vld_pct = 100;
        p_fix_dly = 10;
        tick();
        p_vld_pct = 0;
        repeat (2) tick();
        p_rst_n = 1'b0;
        tick();
        p_rst_n   = 1'b1;
        p_vld_pct = 100;
        o_nstart  = 0;
        repeat (10) tick();
        chk("no_launch_after_reset", o_nstart, 0);
        chk("idle_after_reset", busy, 0);

        // randomized traffic against the model
        p_fix         = 1'b0;
        p_rand_center = 1'b1;
        p_spur_start  = 6;
        p_spur_done   = 10;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) p_vld_pct = int'($urandom_range(100, 30));
            p_rst_n = ($urandom_range(599) != 0);
            tick();
        end
        p_rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/medf_frame_ctrl.md
MEDF_FRAME_CTRL -- requirements
Module: medf_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 640: output pixels per row.
REQ-002 SHALL have parameter IMG_H, default 480: rows per frame.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum RUN cycles to wait for medf_done.
REQ-004 SHALL have port CLK  in  1  system clock; all logic on the rising edge.
REQ-005 SHALL have port RSTn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  frame start pulse.
REQ-007 SHALL have port win_vld  in  1  3x3 window available from the window generator.
REQ-008 SHALL have port win_rdy  out  1  controller accepts a window this cycle.
REQ-009 SHALL have port center_pix  in  8  window centre pixel (data_in4).
REQ-010 SHALL have port medf_start  out  1  launch pulse to the median filter's win_data_sig.
REQ-011 SHALL have port medf_done  in  1  median filter done pulse.
REQ-012 SHALL have port medf_data  in  8  median filter result.
REQ-013 SHALL have port pix_out_vld  out  1  one-cycle output pixel strobe.
REQ-014 SHALL have port pix_out  out  8  output pixel, valid with pix_out_vld.
REQ-015 SHALL have port busy  out  1  frame in progress.
REQ-016 SHALL have port frame_done  out  1  pulse with the last pixel of a frame.
REQ-017 SHALL have port err_tmo  out  1  sticky watchdog error.

Function
REQ-018 SHALL implement FSM states IDLE, ACCEPT, RUN, OUT.
REQ-019 IDLE: busy=0; on start -> ACCEPT, clear col/row counters; start SHALL be ignored in every other state.
REQ-020 ACCEPT: win_rdy=1; the handshake fires on win_vld&win_rdy.
REQ-021 On a handshake for a non-border pixel, medf_start SHALL be asserted combinationally in that same cycle, and the FSM SHALL go to RUN.
REQ-022 RUN: win_rdy=0; on medf_done=1, latch medf_data into pix_out and go to OUT.
REQ-023 Latency: handshake in cycle A -> medf_done in A+4 -> pix_out_vld in A+5; interior throughput SHALL be 1 pixel per 6 cycles.
REQ-024 RUN watchdog: if the cycle count in RUN reaches TIMEOUT without medf_done, set err_tmo, force pix_out=0, and go to OUT.
REQ-025 err_tmo SHALL clear only on reset or on a start that is accepted in IDLE.
REQ-026 OUT: pix_out_vld=1 for exactly one cycle; col increments; at col=IMG_W-1, col wraps to 0 and row increments.
REQ-027 Last pixel (col=IMG_W-1, row=IMG_H-1): frame_done=1 in the same cycle as pix_out_vld; counters clear; next state IDLE.
REQ-028 Otherwise OUT -> ACCEPT.
REQ-029 A medf_done arriving outside RUN SHALL be ignored.
REQ-030 pix_out SHALL hold its value between strobes.
REQ-031 Counter widths SHALL be $clog2(IMG_W) and $clog2(IMG_H); the watchdog counter width SHALL be $clog2(TIMEOUT+1).

Reset
REQ-032 RSTn low at any time, including mid-frame, SHALL force state IDLE, col=0, row=0, watchdog count 0, pix_out=0, and pix_out_vld, frame_done, err_tmo, busy, win_rdy, medf_start all 0.
REQ-033 After RSTn deasserts, the block SHALL not act until the next start.

Configuration
REQ-034 With MEDF_BORDER_BYPASS_EN defined: a border pixel (row 0, row IMG_H-1, col 0, col IMG_W-1) handshake SHALL latch center_pix, keep medf_start=0, and go directly to OUT (pix_out_vld at A+1).
REQ-035 Without MEDF_BORDER_BYPASS_EN: every pixel SHALL go through the filter per REQ-021..023; no border decode logic is present.

Verification (IMG_W=4, IMG_H=3, TIMEOUT=15)
REQ-036 Reset mid-RUN -> all outputs 0 next cycle; a win_vld-only stimulus after release produces no medf_start.
REQ-037 start, win_vld held 1, filter model returns 8'h5A four cycles after launch -> pix_out=8'h5A with pix_out_vld 5 cycles after the handshake; 12 strobes total; frame_done on the 12th; busy falls after it.
REQ-038 Bypass build, center_pix=8'hC3 on pixel (0,0) -> no medf_start, pix_out=8'hC3 one cycle after the handshake; pixel (1,1) launches the filter.
REQ-039 Non-bypass build -> exactly 12 medf_start pulses per frame.
REQ-040 Filter model never returns done -> err_tmo=1 and pix_out=0 after 15 RUN cycles; the frame still completes; err_tmo clears on the next start.
REQ-041 start pulsed while busy, and a spurious medf_done in ACCEPT -> no effect on counters, pixel count, or outputs.
